// File: rtl/seradd_pkg.sv
// Shared types and helpers for the nibble-serial wide adder.
package seradd_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the nibble index register; at least one bit.
  function automatic int unsigned idx_w(input int unsigned nibbles);
    return (nibbles < 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_add.sv
// Combinational 4-bit adder slice with carry-in; result is {c4, s}.
module nibble_add
  import seradd_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_cin,
  output logic [NIBBLE_W-1:0] o_s,
  output logic                o_c4
);

  assign {o_c4, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{NIBBLE_W{1'b0}}, i_cin};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide unsigned adder that time-shares one nibble slice, LSB nibble first.
// Optional result self-check with shadow operands: SERADD_SELFCHECK_EN.
module nibble_serial_adder_ctrl
  import seradd_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
)
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                      cout
`ifdef SERADD_SELFCHECK_EN
  ,
  output logic                      mismatch
`endif
);

  localparam int unsigned W  = NIBBLE_W * NIBBLES;
  localparam int unsigned IW = idx_w(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic [W-1:0]        r_sum;
  logic [W-1:0]        w_sum_next;
  logic [IW-1:0]       r_idx;
  logic                r_carry;
  logic                r_cout;
  logic [NIBBLE_W-1:0] w_na;
  logic [NIBBLE_W-1:0] w_nb;
  logic [NIBBLE_W-1:0] w_ns;
  logic                w_c4;
  logic                w_last;

  assign w_last = (r_idx == LAST_IDX);

  // Index mux feeding the single slice, and the merge of its result into sum.
  always_comb begin
    w_na       = '0;
    w_nb       = '0;
    w_sum_next = r_sum;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (r_idx == IW'(i)) begin
        w_na = r_a[i*NIBBLE_W +: NIBBLE_W];
        w_nb = r_b[i*NIBBLE_W +: NIBBLE_W];
        w_sum_next[i*NIBBLE_W +: NIBBLE_W] = w_ns;
      end
    end
  end

  nibble_add u_nibble_add (
    .i_a  (w_na),
    .i_b  (w_nb),
    .i_cin(r_carry),
    .o_s  (w_ns),
    .o_c4 (w_c4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start)  w_state_next = BUSY;
      BUSY:    if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == BUSY);
    done = (r_state == DONE);
  end

  assign sum  = r_sum;
  assign cout = r_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
          end
        end
        BUSY: begin
          r_sum   <= w_sum_next;
          r_carry <= w_c4;
          r_idx   <= r_idx + IW'(1);
          if (w_last) r_cout <= w_c4;
        end
        default: ;
      endcase
    end
  end

`ifdef SERADD_SELFCHECK_EN
  logic [W-1:0] r_sh_a;
  logic [W-1:0] r_sh_b;
  logic         r_sh_cin;
  logic         r_mismatch;
  logic [W:0]   w_expect;

  assign w_expect = {1'b0, r_sh_a} + {1'b0, r_sh_b} + {{W{1'b0}}, r_sh_cin};

  // Compared on the edge entering DONE using the final slice result, so the
  // registered flag is valid in the same cycle as done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_a     <= '0;
      r_sh_b     <= '0;
      r_sh_cin   <= 1'b0;
      r_mismatch <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_sh_a     <= a;
      r_sh_b     <= b;
      r_sh_cin   <= cin;
      r_mismatch <= 1'b0;
    end else if (r_state == BUSY && w_last) begin
      r_mismatch <= ({w_c4, w_sum_next} != w_expect);
    end
  end

  assign mismatch = r_mismatch;
`endif

endmodule
